// File: rtl/rv32_instr_fetch_pkg.sv
// Shared types for the RV32 fetch stage: instruction word type, the NOP
// presented to decode when nothing valid is available, and the entry format
// carried through the fetch buffer.
package rv32_instr_fetch_pkg;

  typedef logic [31:0] rv_instr_t;

  // addi x0, x0, 0
  localparam rv_instr_t NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    rv_instr_t   instr;
    logic [31:0] pc;
    logic        err;
  } fetch_entry_t;

  // Clears the two low address bits (no compressed instructions).
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/rv32_fetch_buffer.sv
// Small synchronous FIFO of fetch entries between the memory response port
// and the decode-facing output register. Flush empties it and wins over push.
module rv32_fetch_buffer
  import rv32_instr_fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s;
  logic          pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  // Pointer and occupancy next-state; a flush discards everything, including a same-cycle push.
  always_comb begin
    push_s   = push && !flush;
    pop_s    = pop && !flush && (count_q != {CW{1'b0}});
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rv32_instr_fetch_checker.sv
// Protocol checks for the fetch stage: memory must never answer a request that
// was not accepted, and the credit scheme must never overfill the buffer.
module rv32_instr_fetch_checker (
  input logic clk,
  input logic resetn,
  input logic mem_rsp_valid,
  input logic outstanding_zero,
  input logic buf_push,
  input logic buf_pop,
  input logic buf_full
);

  property p_no_orphan_rsp;
    @(posedge clk) disable iff (!resetn) !(mem_rsp_valid && outstanding_zero);
  endproperty

  property p_no_buf_overflow;
    @(posedge clk) disable iff (!resetn) !(buf_push && buf_full && !buf_pop);
  endproperty

  a_no_orphan_rsp:   assert property (p_no_orphan_rsp);
  a_no_buf_overflow: assert property (p_no_buf_overflow);

endmodule

// File: rtl/rv32_instr_fetch.sv
// RV32 instruction fetch stage. Owns the PC, issues in-order word reads with a
// credit limit of BUF_DEPTH (outstanding + buffered), tags responses with their
// PC, drops responses that belong to a path abandoned by a redirect, and holds
// the registered instruction presented to decode.
module rv32_instr_fetch
  import rv32_instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        set_nop,
  output logic        fetch_fault
);

  localparam int          CW      = $clog2(BUF_DEPTH + 1);
  localparam int          PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(BUF_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          halted_q, halted_d;
  rv_instr_t     instr_q, instr_d;
  logic [31:0]   instr_pc_q, instr_pc_d;
  logic          set_nop_q, set_nop_d;
  logic          fetch_fault_q, fetch_fault_d;

  logic [31:0]   pc_fifo_q [BUF_DEPTH];
  logic [PW-1:0] pf_wr_q, pf_wr_d;
  logic [PW-1:0] pf_rd_q, pf_rd_d;

  logic [CW:0]   credit_used_s;
  logic          req_valid_s;
  logic          issue_s;
  logic          rsp_accept_s;
  logic          rsp_drop_s;
  logic          buf_push_s;
  logic          buf_pop_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  buf_head_s;
  logic [CW-1:0] buf_count_s;

  function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  rv32_fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .resetn     (resetn),
    .push       (buf_push_s),
    .push_entry (push_entry_s),
    .pop        (buf_pop_s),
    .flush      (redirect_valid),
    .head       (buf_head_s),
    .count      (buf_count_s)
  );

  rv32_instr_fetch_checker u_chk (
    .clk              (clk),
    .resetn           (resetn),
    .mem_rsp_valid    (mem_rsp_valid),
    .outstanding_zero (outstanding_q == {CW{1'b0}}),
    .buf_push         (buf_push_s && !redirect_valid),
    .buf_pop          (buf_pop_s),
    .buf_full         (buf_count_s == CW'(BUF_DEPTH))
  );

  // Request/response handshake decode. The request is held off during reset so
  // memory never sees a valid while the stage is being cleared.
  always_comb begin
    credit_used_s      = {1'b0, outstanding_q} + {1'b0, buf_count_s};
    req_valid_s        = resetn && !halted_q && !redirect_valid && (credit_used_s < CREDITS);
    issue_s            = req_valid_s && mem_req_ready;
    rsp_accept_s       = mem_rsp_valid && (outstanding_q != {CW{1'b0}});
    rsp_drop_s         = rsp_accept_s && (drop_cnt_q != {CW{1'b0}});
    buf_push_s         = rsp_accept_s && !rsp_drop_s;
    buf_pop_s          = !redirect_valid && !stall && (buf_count_s != {CW{1'b0}});
    push_entry_s.instr = mem_rsp_data;
    push_entry_s.pc    = pc_fifo_q[pf_rd_q];
    push_entry_s.err   = mem_rsp_err;
  end

  // PC, counters, halt flag and decode-facing output register next-state.
  // A redirect outranks stall: everything in flight becomes stale and decode sees a NOP.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(issue_s) - CW'(rsp_accept_s);
    drop_cnt_d    = drop_cnt_q;
    halted_d      = halted_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    set_nop_d     = set_nop_q;
    fetch_fault_d = fetch_fault_q;
    if (redirect_valid) begin
      pc_d          = word_align(redirect_pc);
      drop_cnt_d    = outstanding_d;
      halted_d      = 1'b0;
      instr_d       = NOP_INSTR;
      set_nop_d     = 1'b1;
      fetch_fault_d = 1'b0;
    end else begin
      if (issue_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      if (rsp_drop_s) begin
        drop_cnt_d = drop_cnt_q - CW'(1'b1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (stall) begin
        instr_d = instr_q;
      end else if (buf_pop_s) begin
        instr_d       = buf_head_s.instr;
        instr_pc_d    = buf_head_s.pc;
        set_nop_d     = buf_head_s.err;
        fetch_fault_d = buf_head_s.err;
        halted_d      = halted_q | buf_head_s.err;
      end else begin
        instr_d       = NOP_INSTR;
        set_nop_d     = 1'b1;
        fetch_fault_d = 1'b0;
      end
    end
  end

  // PC FIFO pointers: written at issue, read by every response (dropped ones included).
  always_comb begin
    pf_wr_d = pf_wr_q;
    pf_rd_d = pf_rd_q;
    if (issue_s) begin
      pf_wr_d = pf_inc(pf_wr_q);
    end else begin
      pf_wr_d = pf_wr_q;
    end
    if (rsp_accept_s) begin
      pf_rd_d = pf_inc(pf_rd_q);
    end else begin
      pf_rd_d = pf_rd_q;
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q          <= RESET_PC;
      outstanding_q <= {CW{1'b0}};
      drop_cnt_q    <= {CW{1'b0}};
      halted_q      <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= 32'h0000_0000;
      set_nop_q     <= 1'b1;
      fetch_fault_q <= 1'b0;
      pf_wr_q       <= {PW{1'b0}};
      pf_rd_q       <= {PW{1'b0}};
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      halted_q      <= halted_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      set_nop_q     <= set_nop_d;
      fetch_fault_q <= fetch_fault_d;
      pf_wr_q       <= pf_wr_d;
      pf_rd_q       <= pf_rd_d;
    end
  end

  // PC FIFO storage; an entry is read only after it has been written, so no reset.
  always_ff @(posedge clk) begin
    if (issue_s) begin
      pc_fifo_q[pf_wr_q] <= pc_q;
    end
  end

  assign mem_req_valid = req_valid_s;
  assign mem_req_addr  = word_align(pc_q);
  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign set_nop       = set_nop_q;
  assign fetch_fault   = fetch_fault_q;

endmodule
